player_hit_tracker: RTL and testbench
=====================================

// Module: player_hit_tracker
// PURPOSE
//  Consumes the enemy bullet position (bullet_x/bullet_y) and the player ship x position.
//  Detects bullet/ship hitbox overlap and decrements player health once per bullet strike.
//  Provides a post-hit invulnerability window and a sticky game_over flag.
//  Sits between the enemy shoot logic and the VGA draw/HUD logic.
// PARAMETERS
//  SHIP_Y        8'd110       top row of player ship hitbox (fixed row on 160x120 screen)
//  SHIP_W        8'd8         ship hitbox width, pixels
//  SHIP_H        8'd4         ship hitbox height, pixels
//  START_HEALTH  3'd3         health after reset; legal range 1..7
//  INVULN_TICKS  25_000_000   invulnerability length, clock cycles (0.5 s @ 50 MHz); >=1
// PORTS
//  clock      in   1  50 MHz system clock (CLOCK_50)
//  resetn     in   1  synchronous, active-low reset
//  enable     in   1  game running; low freezes all state and counters
//  ship_x     in   8  player ship left edge
//  bullet_x   in   8  enemy bullet x
//  bullet_y   in   8  enemy bullet y (0 = top; restarts at 0 on each new shot)
//  hit        out  1  one-cycle pulse per counted strike
//  health     out  3  remaining health
//  invuln     out  1  high during invulnerability window (HUD blink)
//  game_over  out  1  sticky high once health reaches 0
// BEHAVIOUR
//  Reset (resetn low at posedge): state=ALIVE, health=START_HEALTH, hit=0, invuln=0,
//   game_over=0, armed=1, cnt=0. Reset beats every other event on the same edge.
//  Overlap (combinational, 9-bit math, no wrap):
//   ship_x <= bullet_x <= ship_x+SHIP_W-1  AND  SHIP_Y <= bullet_y <= SHIP_Y+SHIP_H-1.
//   ship_x+SHIP_W beyond 255 stays correct via the 9-bit compare.
//  armed: cleared on a counted strike; set on any enabled cycle with bullet_y < SHIP_Y
//   (new shot). One bullet is counted at most once.
//  enable low: state, cnt, health, armed held; hit=0; no strike counted.
//  FSM, all transitions need enable=1:
//   ALIVE : overlap & armed -> strike: health-=1, hit=1 on next cycle (1-cycle latency
//           from sampled inputs), armed=0. health was 1 -> DEAD, else -> INVULN with
//           cnt=INVULN_TICKS-1, invuln=1.
//   INVULN: overlaps ignored; armed still updated. cnt-=1 per cycle; at cnt==0 -> ALIVE,
//           invuln=0 next cycle. Window lasts exactly INVULN_TICKS enabled cycles.
//   DEAD  : game_over=1, health=0, invuln=0, hit=0; left only by reset.
//  hit never exceeds one cycle; health never underflows (saturates at 0).
//  Overlap and re-arm on the same cycle are impossible: bullet_y < SHIP_Y vs >= SHIP_Y.
// STRUCTURE
//  Shared package starflux_pkg: SCREEN_W=160, SCREEN_H=120, COORD_W=8,
//   ship geometry defaults, hit_state_t enum {ALIVE, INVULN, DEAD}.
//  Sub-module hitbox_overlap: combinational rect/point compare (x, y, rect origin,
//   W, H -> overlap). Reusable for player-bullet vs enemy.
//  Top: FSM, invuln down-counter, health register, armed flag, output registers.
// TESTING (bench params: INVULN_TICKS=4, START_HEALTH=3, SHIP_Y=110)
//  1 Reset: resetn=0 for 2 cycles -> health=3, hit=0, invuln=0, game_over=0.
//  2 Strike: ship_x=50, bullet_x=53, bullet_y=110 -> hit=1 one cycle later for exactly
//    1 cycle, health=2, invuln=1 for 4 cycles, then invuln=0.
//  3 No double count: hold bullet_y=111 through and after the window -> no 2nd hit;
//    bullet_y=0 then 110 -> 2nd hit, health=1.
//  4 Edges: ship_x=50: bullet_x=49 or 58 -> no hit; 50 and 57 -> hit;
//    ship_x=252, bullet_x=255 -> hit.
//  5 Death: third strike -> health=0, game_over=1 sticky; further overlaps give no hit;
//    resetn=0 -> health=3, game_over=0.
//  6 Freeze: enable=0 mid-INVULN with cnt=2 for 10 cycles -> cnt/invuln held,
//    overlap ignored; enable=1 -> invuln drops after 3 more cycles.

Source files
------------

// File: rtl/starflux_pkg.sv
// Shared game constants, screen geometry and player hit-state encoding.
package starflux_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int COORD_W  = 8;
   localparam int HEALTH_W = 3;

   localparam logic [COORD_W-1:0]  SHIP_Y_DEF       = 8'd110;
   localparam logic [COORD_W-1:0]  SHIP_W_DEF       = 8'd8;
   localparam logic [COORD_W-1:0]  SHIP_H_DEF       = 8'd4;
   localparam logic [HEALTH_W-1:0] START_HEALTH_DEF = 3'd3;
   localparam int                  INVULN_TICKS_DEF = 25_000_000;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } hit_state_t;

   // Health never wraps below zero.
   function automatic logic [HEALTH_W-1:0] dec_sat(input logic [HEALTH_W-1:0] v);
      return (v == '0) ? v : v - HEALTH_W'(1);
   endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Point-in-rectangle test; one extra bit keeps rectangles near the right/bottom edge from wrapping.
module hitbox_overlap
   import starflux_pkg::*;
#(
   parameter logic [COORD_W-1:0] W = SHIP_W_DEF,
   parameter logic [COORD_W-1:0] H = SHIP_H_DEF
) (
   input  logic [COORD_W-1:0] i_px,
   input  logic [COORD_W-1:0] i_py,
   input  logic [COORD_W-1:0] i_rx,
   input  logic [COORD_W-1:0] i_ry,
   output logic               o_overlap
);

   logic [COORD_W:0] w_x_end;
   logic [COORD_W:0] w_y_end;
   logic             w_in_x;
   logic             w_in_y;

   assign w_x_end = {1'b0, i_rx} + {1'b0, W} - (COORD_W+1)'(1);
   assign w_y_end = {1'b0, i_ry} + {1'b0, H} - (COORD_W+1)'(1);

   assign w_in_x = ({1'b0, i_px} >= {1'b0, i_rx}) && ({1'b0, i_px} <= w_x_end);
   assign w_in_y = ({1'b0, i_py} >= {1'b0, i_ry}) && ({1'b0, i_py} <= w_y_end);

   assign o_overlap = w_in_x && w_in_y;

endmodule

// File: rtl/player_hit_tracker.sv
// Player damage tracking: counts each enemy bullet strike once, runs the post-hit
// invulnerability window and latches game over when health runs out.
module player_hit_tracker
   import starflux_pkg::*;
#(
   parameter logic [COORD_W-1:0]  SHIP_Y       = SHIP_Y_DEF,
   parameter logic [COORD_W-1:0]  SHIP_W       = SHIP_W_DEF,
   parameter logic [COORD_W-1:0]  SHIP_H       = SHIP_H_DEF,
   parameter logic [HEALTH_W-1:0] START_HEALTH = START_HEALTH_DEF,
   parameter int                  INVULN_TICKS = INVULN_TICKS_DEF
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                enable,
   input  logic [COORD_W-1:0]  ship_x,
   input  logic [COORD_W-1:0]  bullet_x,
   input  logic [COORD_W-1:0]  bullet_y,
   output logic                hit,
   output logic [HEALTH_W-1:0] health,
   output logic                invuln,
   output logic                game_over
);

   localparam int               CNT_W    = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_TICKS - 1);

   hit_state_t           r_state,  w_state_nxt;
   logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
   logic [HEALTH_W-1:0]  r_health, w_health_nxt;
   logic                 r_armed,  w_armed_nxt;
   logic                 r_hit,    w_hit_nxt;
   logic                 w_overlap;
   logic                 w_new_shot;

   hitbox_overlap #(
      .W (SHIP_W),
      .H (SHIP_H)
   ) u_ship_box (
      .i_px      (bullet_x),
      .i_py      (bullet_y),
      .i_rx      (ship_x),
      .i_ry      (SHIP_Y),
      .o_overlap (w_overlap)
   );

   // A bullet above the ship row is a fresh shot; it can never overlap on the same cycle.
   assign w_new_shot = (bullet_y < SHIP_Y);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= ALIVE;
         r_cnt    <= '0;
         r_health <= START_HEALTH;
         r_armed  <= 1'b1;
         r_hit    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_health <= w_health_nxt;
         r_armed  <= w_armed_nxt;
         r_hit    <= w_hit_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_health_nxt = r_health;
      w_armed_nxt  = r_armed;
      w_hit_nxt    = 1'b0;
      if (enable) begin
         if (w_new_shot) w_armed_nxt = 1'b1;
         case (r_state)
            ALIVE: begin
               if (w_overlap && r_armed) begin
                  w_hit_nxt    = 1'b1;
                  w_armed_nxt  = 1'b0;
                  w_health_nxt = dec_sat(r_health);
                  if (r_health <= HEALTH_W'(1)) begin
                     w_state_nxt = DEAD;
                  end else begin
                     w_state_nxt = INVULN;
                     w_cnt_nxt   = CNT_LOAD;
                  end
               end
            end
            INVULN: begin
               if (r_cnt == '0) w_state_nxt = ALIVE;
               else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            DEAD: begin
               w_health_nxt = '0;
            end
            default: begin
               w_state_nxt = ALIVE;
            end
         endcase
      end
   end

   assign hit       = r_hit;
   assign health    = r_health;
   assign invuln    = (r_state == INVULN);
   assign game_over = (r_state == DEAD);

endmodule

// File: tb/tb_player_hit_tracker.sv
// Directed bench for player_hit_tracker with a 4-cycle invulnerability window.
module tb_player_hit_tracker;

   logic       clock = 1'b0;
   logic       resetn;
   logic       enable;
   logic [7:0] ship_x;
   logic [7:0] bullet_x;
   logic [7:0] bullet_y;
   logic       hit;
   logic [2:0] health;
   logic       invuln;
   logic       game_over;

   int n_checks = 0;
   int n_fail   = 0;

   player_hit_tracker #(
      .SHIP_Y       (8'd110),
      .SHIP_W       (8'd8),
      .SHIP_H       (8'd4),
      .START_HEALTH (3'd3),
      .INVULN_TICKS (4)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .enable    (enable),
      .ship_x    (ship_x),
      .bullet_x  (bullet_x),
      .bullet_y  (bullet_y),
      .hit       (hit),
      .health    (health),
      .invuln    (invuln),
      .game_over (game_over)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      enable = 1'b1; ship_x = 8'd50; bullet_x = 8'd53; bullet_y = 8'd110;
      do_reset();
      n_checks++; if (health !== 3'd3) begin n_fail++; $display("FAIL reset_health: got %0d want 3", health); end
      n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", hit); end
      n_checks++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL reset_invuln: got %0b want 0", invuln); end
      n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
      bullet_y = 8'd0;
   endtask

   // Strike, then hold the same bullet inside the hitbox through and after the window.
   task automatic test_strike_no_double();
      do_reset();
      ship_x = 8'd50; bullet_x = 8'd53; bullet_y = 8'd110;
      tick();
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL strike_hit: got %0b want 1", hit); end
      n_checks++; if (health !== 3'd2) begin n_fail++; $display("FAIL strike_health: got %0d want 2", health); end
      n_checks++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL strike_invuln0: got %0b want 1", invuln); end
      bullet_y = 8'd111;
      tick();
      n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL strike_hit_width: got %0b want 0", hit); end
      for (int i = 1; i < 4; i++) begin
         n_checks++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL window_cycle%0d: got %0b want 1", i, invuln); end
         tick();
      end
      n_checks++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL window_end: got %0b want 0", invuln); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (hit !== 1'b0 || health !== 3'd2) begin n_fail++; $display("FAIL no_double%0d: hit %0b health %0d want 0/2", i, hit, health); end
      end
      bullet_y = 8'd0;
      tick();
      bullet_y = 8'd110;
      tick();
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL second_hit: got %0b want 1", hit); end
      n_checks++; if (health !== 3'd1) begin n_fail++; $display("FAIL second_health: got %0d want 1", health); end
      bullet_y = 8'd0;
   endtask

   task automatic test_edges();
      logic [7:0] sx [8] = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd252, 8'd252, 8'd50, 8'd50};
      logic [7:0] bx [8] = '{8'd49, 8'd58, 8'd50, 8'd57, 8'd255, 8'd251, 8'd53, 8'd53};
      logic [7:0] by [8] = '{8'd110, 8'd110, 8'd110, 8'd110, 8'd110, 8'd110, 8'd113, 8'd114};
      logic       eh [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         do_reset();
         ship_x = sx[i]; bullet_x = bx[i]; bullet_y = by[i];
         tick();
         n_checks++;
         if (hit !== eh[i] || health !== (eh[i] ? 3'd2 : 3'd3)) begin
            n_fail++;
            $display("FAIL edge%0d ship %0d bx %0d by %0d: hit %0b health %0d want hit %0b", i, sx[i], bx[i], by[i], hit, health, eh[i]);
         end
      end
      bullet_y = 8'd0;
   endtask

   task automatic test_death();
      logic [2:0] exp_h;
      do_reset();
      ship_x = 8'd50; bullet_x = 8'd53;
      for (int s = 0; s < 3; s++) begin
         bullet_y = 8'd0;
         tick();
         bullet_y = 8'd110;
         tick();
         exp_h = 3'(2 - s);
         n_checks++; if (hit !== 1'b1 || health !== exp_h) begin n_fail++; $display("FAIL death_strike%0d: hit %0b health %0d want 1/%0d", s, hit, health, exp_h); end
         bullet_y = 8'd0;
         tick(4);
      end
      n_checks++; if (game_over !== 1'b1 || invuln !== 1'b0) begin n_fail++; $display("FAIL death_flags: game_over %0b invuln %0b want 1/0", game_over, invuln); end
      for (int i = 0; i < 3; i++) begin
         bullet_y = 8'd0;
         tick();
         bullet_y = 8'd110;
         tick();
         n_checks++; if (hit !== 1'b0 || health !== 3'd0 || game_over !== 1'b1) begin n_fail++; $display("FAIL dead_sticky%0d: hit %0b health %0d go %0b want 0/0/1", i, hit, health, game_over); end
      end
      do_reset();
      n_checks++; if (health !== 3'd3 || game_over !== 1'b0) begin n_fail++; $display("FAIL death_reset: health %0d go %0b want 3/0", health, game_over); end
      bullet_y = 8'd0;
   endtask

   task automatic test_freeze();
      do_reset();
      ship_x = 8'd50; bullet_x = 8'd53; bullet_y = 8'd110;
      tick();
      bullet_y = 8'd0;
      tick();
      enable = 1'b0; bullet_y = 8'd110;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (invuln !== 1'b1 || hit !== 1'b0 || health !== 3'd2) begin n_fail++; $display("FAIL freeze%0d: invuln %0b hit %0b health %0d want 1/0/2", i, invuln, hit, health); end
      end
      enable = 1'b1; bullet_y = 8'd0;
      tick();
      n_checks++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL thaw1: got %0b want 1", invuln); end
      tick();
      n_checks++; if (invuln !== 1'b1) begin n_fail++; $display("FAIL thaw2: got %0b want 1", invuln); end
      tick();
      n_checks++; if (invuln !== 1'b0) begin n_fail++; $display("FAIL thaw3: got %0b want 0", invuln); end
      enable = 1'b0; bullet_y = 8'd110;
      tick(3);
      n_checks++; if (hit !== 1'b0 || health !== 3'd2) begin n_fail++; $display("FAIL freeze_alive: hit %0b health %0d want 0/2", hit, health); end
      enable = 1'b1;
      tick();
      n_checks++; if (hit !== 1'b1 || health !== 3'd1) begin n_fail++; $display("FAIL unfreeze_hit: hit %0b health %0d want 1/1", hit, health); end
      bullet_y = 8'd0;
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b1;
      ship_x = 8'd0; bullet_x = 8'd0; bullet_y = 8'd0;
      test_reset();
      test_strike_no_double();
      test_edges();
      test_death();
      test_freeze();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
